// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory request/response bus between fetch and imem
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  // Fetch stage drives the request side.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  // Instruction memory answers with a one-cycle ready strobe.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage with one-entry skid buffer and redirect flush
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  if_stage_if.master  imem,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] drop_addr, drop_addr_nxt;
  logic [31:0] buf_instr, buf_instr_nxt;
  logic [31:0] buf_pc4, buf_pc4_nxt;
  logic [31:0] instr_nxt, pc4_out_nxt;
  logic        valid_nxt;
  logic [31:0] pc_inc;
  logic        out_free;

  assign pc_inc   = pc + 32'd4;
  // A held instruction only blocks the output register while decode is stalled.
  assign out_free = !instr_valid || !stall;

  // While dropping, the in-flight request keeps its original address even though pc already holds the target.
  assign imem.imem_req  = (state == S_REQ) || (state == S_DROP);
  assign imem.imem_addr = (state == S_DROP) ? drop_addr : pc;

  // Next-state and datapath update; redirect outranks stall and any same-cycle response.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    drop_addr_nxt = drop_addr;
    buf_instr_nxt = buf_instr;
    buf_pc4_nxt   = buf_pc4;
    instr_nxt     = instr_out;
    pc4_out_nxt   = pc_plus4_out;
    valid_nxt     = instr_valid;

    case (state)
      S_BOOT: begin
        state_nxt = S_REQ;
        if (redirect) begin
          pc_nxt    = redirect_pc;
          instr_nxt = NOP_INSTR;
          valid_nxt = 1'b0;
        end
      end

      S_REQ: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          instr_nxt = NOP_INSTR;
          valid_nxt = 1'b0;
          if (!imem.imem_ready) begin
            state_nxt     = S_DROP;
            drop_addr_nxt = pc;
          end
        end else if (imem.imem_ready) begin
          pc_nxt = pc_inc;
          if (out_free) begin
            instr_nxt   = imem.imem_rdata;
            pc4_out_nxt = pc_inc;
            valid_nxt   = 1'b1;
          end else begin
            buf_instr_nxt = imem.imem_rdata;
            buf_pc4_nxt   = pc_inc;
            state_nxt     = S_FULL;
          end
        end else if (!stall) begin
          instr_nxt = NOP_INSTR;
          valid_nxt = 1'b0;
        end
      end

      S_FULL: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          instr_nxt = NOP_INSTR;
          valid_nxt = 1'b0;
          state_nxt = S_REQ;
        end else if (!stall) begin
          instr_nxt   = buf_instr;
          pc4_out_nxt = buf_pc4;
          valid_nxt   = 1'b1;
          state_nxt   = S_REQ;
        end
      end

      S_DROP: begin
        if (redirect) begin
          pc_nxt = redirect_pc;
        end
        // The abandoned request still owes one response; leave only once it has arrived.
        if (imem.imem_ready) begin
          state_nxt = S_REQ;
        end
      end

      default: begin
        state_nxt = S_BOOT;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // PC, skid buffer and decode-facing output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc           <= RESET_PC;
      drop_addr    <= 32'd0;
      buf_instr    <= NOP_INSTR;
      buf_pc4      <= 32'd0;
      instr_out    <= NOP_INSTR;
      pc_plus4_out <= 32'd0;
      instr_valid  <= 1'b0;
    end else begin
      pc           <= pc_nxt;
      drop_addr    <= drop_addr_nxt;
      buf_instr    <= buf_instr_nxt;
      buf_pc4      <= buf_pc4_nxt;
      instr_out    <= instr_nxt;
      pc_plus4_out <= pc4_out_nxt;
      instr_valid  <= valid_nxt;
    end
  end

endmodule
